// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with an 8-entry register file (reg 7 reads 8'hA5).
// Define I2C_TARGET_AUTOINC_EN to auto-increment the pointer after each acked byte.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_pulse,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] ctrl_out,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK} state_t;
  state_t st;
  logic scl_s1, scl_s2, scl_q, sda_s1, sda_s2, sda_q;
  logic scl_rise, scl_fall, start, stop, mack;
  logic [3:0] cnt;
  logic [7:0] sh, byte_in, rd_cur, rd_nxt;
  logic [2:0] ptr, ptr_inc;
  logic [7:0] regs [0:6];
  assign scl_rise = scl_s2 & ~scl_q;
  assign scl_fall = ~scl_s2 & scl_q;
  assign start    = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop     = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign byte_in  = {sh[6:0], sda_s2};
`ifdef I2C_TARGET_AUTOINC_EN
  assign ptr_inc  = ptr + 3'd1;
`else
  assign ptr_inc  = ptr;
`endif
  assign rd_cur   = (ptr == 3'd7) ? 8'hA5 : regs[ptr];
  assign rd_nxt   = (ptr_inc == 3'd7) ? 8'hA5 : regs[ptr_inc];
  assign ctrl_out = regs[0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {scl_s1, scl_s2, scl_q, sda_s1, sda_s2, sda_q} <= 6'h3f;
      st       <= IDLE;
      ptr      <= 3'd0;
      cnt      <= 4'd0;
      sh       <= 8'h00;
      mack     <= 1'b0;
      sda_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= 3'd0;
      wr_data  <= 8'h00;
      busy     <= 1'b0;
      for (int i = 0; i < 7; i++) regs[i] <= 8'h00;
    end else begin
      scl_s1   <= scl_i;
      scl_s2   <= scl_s1;
      scl_q    <= scl_s2;
      sda_s1   <= sda_i;
      sda_s2   <= sda_s1;
      sda_q    <= sda_s2;
      wr_pulse <= 1'b0;
      if (start) begin
        st     <= ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop) begin
        st     <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (st)
          ADDR, PTR, WDATA: begin
            if (scl_rise && cnt < 4'd8) begin
              sh  <= byte_in;
              cnt <= cnt + 4'd1;
              // the write lands on the 8th rise, before the ack slot
              if (st == WDATA && cnt == 4'd7 && ptr != 3'd7) begin
                regs[ptr] <= byte_in;
                wr_pulse  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= byte_in;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= 4'd0;
              if (st == ADDR) begin
                st     <= (sh[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
                sda_oe <= sh[7:1] == TARGET_ADDR;
                busy   <= sh[7:1] == TARGET_ADDR;
              end else if (st == PTR) begin
                st     <= (sh < 8'd8) ? PTR_ACK : IDLE;
                sda_oe <= sh < 8'd8;
                ptr    <= (sh < 8'd8) ? sh[2:0] : ptr;
              end else begin
                st     <= WDATA_ACK;
                sda_oe <= 1'b1;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            st     <= sh[0] ? RDATA : PTR;
            sda_oe <= sh[0] & ~rd_cur[7];
            sh     <= rd_cur;
            cnt    <= 4'd0;
          end
          PTR_ACK: if (scl_fall) begin
            st     <= WDATA;
            sda_oe <= 1'b0;
          end
          WDATA_ACK: if (scl_fall) begin
            st     <= WDATA;
            sda_oe <= 1'b0;
            ptr    <= ptr_inc;
          end
          RDATA: if (scl_fall) begin
            st     <= (cnt == 4'd7) ? RACK : RDATA;
            sda_oe <= (cnt == 4'd7) ? 1'b0 : ~sh[6];
            sh     <= {sh[6:0], 1'b0};
            cnt    <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
          end
          RACK: begin
            if (scl_rise) mack <= ~sda_s2;
            if (scl_fall) begin
              st     <= mack ? RDATA : IDLE;
              sda_oe <= mack & ~rd_nxt[7];
              sh     <= rd_nxt;
              ptr    <= mack ? ptr_inc : ptr;
              cnt    <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed table-driven bench acting as I2C master.
module tb_i2c_target_regfile;
  logic clk = 0, rst_n = 0, scl = 1, sda_m = 1;
  logic sda_i, sda_oe, wr_pulse, busy;
  logic [2:0] wr_addr;
  logic [7:0] wr_data, ctrl_out;
  int total = 0, bad = 0, npulse = 0, oe_cnt = 0;
  logic [2:0] last_a = 0;
  logic [7:0] last_d = 0;

  assign sda_i = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regfile dut (.clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .ctrl_out(ctrl_out), .busy(busy));

  always @(negedge clk) begin
    if (wr_pulse) begin
      npulse <= npulse + 1;
      last_a <= wr_addr;
      last_d <= wr_data;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_pack;
    logic       exp_pulse;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t v [6];

  task automatic hw;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic start_c;
    sda_m = 1; hw; scl = 1; hw; sda_m = 0; hw; scl = 0; hw;
  endtask

  task automatic stop_c;
    sda_m = 0; hw; scl = 1; hw; sda_m = 1; hw;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; hw; scl = 1; hw; scl = 0; hw;
    end
    sda_m = 1; hw; scl = 1; hw; ack = ~sda_i; scl = 0; hw;
  endtask

  task automatic rbyte(input logic ack_m, output logic [7:0] b);
    sda_m = 1;
    for (int i = 7; i >= 0; i--) begin
      hw; scl = 1; hw; b[i] = sda_i; scl = 0;
    end
    sda_m = ~ack_m; hw; scl = 1; hw; scl = 0; hw; sda_m = 1;
  endtask

  task automatic rd_txn(input logic [7:0] p, output logic [7:0] d);
    logic a;
    start_c; wbyte(8'h88, a); wbyte(p, a);
    start_c; wbyte(8'h89, a); rbyte(1'b0, d); stop_c;
  endtask

  initial begin
    logic a, pa, da;
    logic [7:0] d, d2;
    int p0, o0;
    v[0] = '{8'h02, 8'h5A, 1'b1, 1'b1, 8'h5A};
    v[1] = '{8'h00, 8'hC3, 1'b1, 1'b1, 8'hC3};
    v[2] = '{8'h03, 8'h3C, 1'b1, 1'b1, 8'h3C};
    v[3] = '{8'h06, 8'h7E, 1'b1, 1'b1, 8'h7E};
    v[4] = '{8'h07, 8'h12, 1'b1, 1'b0, 8'hA5};
    v[5] = '{8'h0A, 8'h55, 1'b0, 1'b0, 8'h00};
    repeat (4) @(negedge clk);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst busy", busy, 0);
    chk("rst ctrl_out", ctrl_out, 0);
    chk("rst wr_addr/data", {wr_addr, wr_data}, 0);
    rst_n = 1; hw;

    // wrong address: no ack, bus ignored
    p0 = npulse;
    start_c; wbyte(8'hA0, a);
    chk("bad addr ack", a, 0);
    chk("bad addr busy", busy, 0);
    wbyte(8'h02, a); chk("ignored byte1 ack", a, 0);
    wbyte(8'h33, a); chk("ignored byte2 ack", a, 0);
    stop_c;
    chk("bad addr pulses", npulse - p0, 0);

    for (int k = 0; k < 6; k++) begin
      p0 = npulse;
      start_c; wbyte(8'h88, a);
      chk($sformatf("v%0d addr ack", k), a, 1);
      chk($sformatf("v%0d busy", k), busy, 1);
      wbyte(v[k].ptr, pa);
      chk($sformatf("v%0d ptr ack", k), pa, v[k].exp_pack);
      wbyte(v[k].data, da);
      chk($sformatf("v%0d data ack", k), da, v[k].exp_pack);
      stop_c;
      chk($sformatf("v%0d busy after stop", k), busy, 0);
      chk($sformatf("v%0d pulses", k), npulse - p0, v[k].exp_pulse);
      if (v[k].exp_pulse) chk($sformatf("v%0d wr addr/data", k), {last_a, last_d}, {v[k].ptr[2:0], v[k].data});
      if (v[k].exp_pack) begin
        rd_txn(v[k].ptr, d);
        chk($sformatf("v%0d readback", k), d, v[k].exp_rd);
      end
    end
    chk("ctrl_out reg0", ctrl_out, 8'hC3);

    // pointer left at 7 by the last readback; 0x0A must not move it
    start_c; wbyte(8'h89, a); rbyte(1'b0, d); stop_c;
    chk("ptr kept after 0x0A", d, 8'hA5);

    // pointer 0x09: nack, following byte ignored, pointer unchanged
    rd_txn(8'h03, d);
    p0 = npulse;
    start_c; wbyte(8'h88, a); wbyte(8'h09, pa);
    chk("ptr 0x09 nack", pa, 0);
    wbyte(8'h77, da);
    chk("after 0x09 ignored", da, 0);
    stop_c;
    chk("after 0x09 pulses", npulse - p0, 0);
    start_c; wbyte(8'h89, a); rbyte(1'b0, d); stop_c;
    chk("ptr kept after 0x09", d, 8'h3C);

    // burst write starting at reg 6
    p0 = npulse;
    start_c; wbyte(8'h88, a); wbyte(8'h06, a);
    wbyte(8'h11, a); wbyte(8'h22, a); wbyte(8'h33, da); stop_c;
    chk("burst last ack", da, 1);
    rd_txn(8'h06, d);
`ifdef I2C_TARGET_AUTOINC_EN
    chk("burst pulses", npulse - p0, 2);
    chk("burst reg6", d, 8'h11);
    chk("burst ctrl_out", ctrl_out, 8'h33);
    rd_txn(8'h07, d);
    chk("burst reg7", d, 8'hA5);
`else
    chk("burst pulses", npulse - p0, 3);
    chk("burst reg6", d, 8'h33);
    chk("burst ctrl_out", ctrl_out, 8'hC3);
`endif

    // two-byte read: ack then nack
    start_c; wbyte(8'h88, a); wbyte(8'h02, a);
    start_c; wbyte(8'h89, a); rbyte(1'b1, d); rbyte(1'b0, d2); stop_c;
    chk("multi read b0", d, 8'h5A);
`ifdef I2C_TARGET_AUTOINC_EN
    chk("multi read b1", d2, 8'h3C);
`else
    chk("multi read b1", d2, 8'h5A);
`endif

    // reset while driving a read bit low
    start_c; wbyte(8'h88, a); wbyte(8'h02, a);
    start_c; wbyte(8'h89, a);
    chk("rdata driving", sda_oe, 1);
    rst_n = 0;
    @(negedge clk);
    chk("reset releases sda", sda_oe, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset ctrl_out", ctrl_out, 0);
    o0 = oe_cnt;
    for (int i = 0; i < 9; i++) begin
      sda_m = i[0]; hw; scl = 1; hw; scl = 0; hw;
    end
    sda_m = 1; hw; scl = 1; hw;
    chk("bus ignored after reset", oe_cnt - o0, 0);
    rd_txn(8'h02, d);
    chk("reg2 cleared", d, 8'h00);
    rd_txn(8'h07, d);
    chk("reg7 after reset", d, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter: TARGET_ADDR, default 7'h44, 7-bit bus address this target acknowledges.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: scl_i  input  1  raw I2C clock from the bus, asynchronous.
REQ-005 SHALL have port: sda_i  input  1  raw I2C data from the wired-AND bus, asynchronous.
REQ-006 SHALL have port: sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
REQ-007 SHALL have port: wr_pulse  output  1  one-clk strobe per accepted register write.
REQ-008 SHALL have port: wr_addr  output  3  register index of the write; valid with wr_pulse.
REQ-009 SHALL have port: wr_data  output  8  data of the write; valid with wr_pulse.
REQ-010 SHALL have port: ctrl_out  output  8  live value of register 0.
REQ-011 SHALL have port: busy  output  1  1 from address-match ACK until STOP or next START.

Function
REQ-012 SHALL synchronise scl_i and sda_i through 2 flops each; edge detection SHALL use the synchronised values only.
REQ-013 SHALL detect START as synchronised SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1; either SHALL be recognised in any state.
REQ-014 SHALL sample data bits on SCL rising edges, MSB first, and change sda_oe only on the clk after a detected SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
REQ-016 START -> ADDR from any state (repeated START included); STOP -> IDLE from any state, sda_oe=0 within 1 clk.
REQ-017 ADDR: after 8 bits, if addr[7:1]==TARGET_ADDR -> ADDR_ACK (drive 0 for one SCL low/high period); else -> IDLE, no ACK (NACK), ignore bus until next START.
REQ-018 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA using the current pointer.
REQ-019 PTR: byte value 0..7 -> load pointer, ACK, go to WDATA; value >=8 -> NACK, pointer unchanged, go to IDLE.
REQ-020 WDATA: each byte ACKed; pointer 0..6 -> register updated and wr_pulse/wr_addr/wr_data asserted for exactly 1 clk on the 8th SCL rise; pointer 7 -> ACKed, no update, no wr_pulse.
REQ-021 Register 7 SHALL be read-only, constant 8'hA5; registers 0..6 reset to 8'h00.
REQ-022 RDATA: shift out register[pointer] MSB first, driving sda_oe=~bit; in RACK release SDA and sample master ACK: ACK (0) -> next byte; NACK (1) -> IDLE.
REQ-023 Write data received while sda_oe would conflict SHALL not occur: sda_oe=0 in all states except ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA.
REQ-024 Target SHALL function with SCL high and low phases each >= 6 clk.

Reset
REQ-025 With rst_n=0 at a clk edge: state=IDLE, pointer=0, sda_oe=0, wr_pulse=0, wr_addr=0, wr_data=0, busy=0, registers 0..6=0, ctrl_out=0, synchroniser flops=1.
REQ-026 Reset asserted mid-transfer SHALL release SDA on the next clk and ignore the bus until a fresh START.

Configuration
REQ-027 Macro I2C_TARGET_AUTOINC_EN defined: pointer increments after each ACKed write byte and each master-ACKed read byte, wrapping 7->0.
REQ-028 Macro not defined: pointer stays fixed for the whole transaction; repeated writes overwrite the same register, repeated reads return the same register.

Verification
REQ-029 Write 0x88 (addr 0x44,W), 0x02, 0x5A, STOP -> ACK,ACK,ACK; one wr_pulse with wr_addr=2, wr_data=0x5A.
REQ-030 Address 0x50,W -> SDA released on 9th clock (NACK), busy=0, no wr_pulse; following transfer to 0x44 ACKed normally.
REQ-031 Write ptr 0x07, repeated START, 0x89 read one byte with NACK -> data 0xA5, then IDLE; write to reg 7 gives ACK, no wr_pulse.
REQ-032 Pointer byte 0x09 -> NACK on 9th clock, pointer unchanged, state IDLE.
REQ-033 With I2C_TARGET_AUTOINC_EN: ptr 0x06, data 0x11,0x22,0x33 -> reg6=0x11, reg7 unchanged, reg0=0x33, ctrl_out=0x33; without macro: reg6=0x33.
REQ-034 rst_n low during RDATA with sda_oe=1 -> sda_oe=0 next clk, all registers 0, bus ignored until START.
